mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum ACCESS-state cycles allowed before the access is abandoned.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low; the block has one clock and no other reset.
REQ-004 ex_mem_memread  input  1  EX/MEM stage holds a load.
REQ-005 ex_mem_memwrite  input  1  EX/MEM stage holds a store.
REQ-006 ex_mem_FWD_RS2  input  2  store-data source: 2'b00 = ex_mem_output_data_2; 2'b01 or 2'b10 = wb_result; 2'b11 = ex_mem_output_data_2.
REQ-007 ex_mem_addr  input  32  effective address.
REQ-008 ex_mem_output_data_2  input  32  rs2 value carried in EX/MEM.
REQ-009 wb_result  input  32  value being written back in the current cycle.
REQ-010 mem_req  output  1  memory request, registered, held until acknowledged.
REQ-011 mem_we  output  1  1 = write, 0 = read; registered.
REQ-012 mem_addr  output  32  registered address.
REQ-013 mem_wdata  output  32  registered store data.
REQ-014 mem_ack  input  1  one-cycle completion from memory.
REQ-015 mem_rdata  input  32  read data, valid when mem_ack = 1.
REQ-016 stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers.
REQ-017 read_data  output  32  captured load data, registered.
REQ-018 read_valid  output  1  one-cycle pulse indicating read_data is valid.
REQ-019 timeout_err  output  1  sticky flag indicating the last access timed out.

Function
REQ-020 FSM states: IDLE, ACCESS, DONE.
REQ-021 IDLE, request = memread OR memwrite: stall = 1 combinationally in the same cycle. On the clock edge, load mem_addr, mem_we = memwrite, mem_wdata = forward-selected store data; set mem_req = 1; clear timeout_err and the counter; transition to ACCESS.
REQ-022 When memread and memwrite are both 1, the access is a write.
REQ-023 ACCESS: stall = 1; mem_req, mem_we, mem_addr and mem_wdata are held stable; the counter increments each cycle mem_ack = 0.
REQ-024 ACCESS with mem_ack = 1: mem_req -> 0. On a read, read_data <- mem_rdata. Transition to DONE.
REQ-025 ACCESS with counter = TIMEOUT-1 and mem_ack = 0: mem_req -> 0, timeout_err -> 1, read_data -> 0, transition to DONE.
REQ-026 When mem_ack and the timeout occur in the same cycle, mem_ack wins and timeout_err stays 0.
REQ-027 DONE: stall = 0; read_valid = 1 for exactly this cycle, and only for reads (timed-out reads included). Inputs are ignored in DONE; the next state is always IDLE.
REQ-028 mem_ack is ignored in IDLE and DONE.
REQ-029 Minimum latency is 3 cycles from request to return to IDLE. With mem_ack on the first ACCESS cycle, stall is high for exactly 2 cycles.
REQ-030 The counter width is clog2(TIMEOUT)+1. The counter saturates and never wraps.
REQ-031 read_data holds its value until the next read completes or times out.

Reset
REQ-032 rst_n = 0 forces the following asynchronously, including mid-access: state = IDLE, counter = 0, and mem_req, mem_we, mem_addr, mem_wdata, read_data, read_valid and timeout_err = 0.
REQ-033 stall is 0 during reset. After release, the first clk edge evaluates IDLE normally.

Structure
REQ-034 Shared package mem_ctrl_pkg holds the state encoding, the FWD_RS2 encodings (FWD_NONE = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10) and the default TIMEOUT.
REQ-035 One combinational sub-module, store_fwd_sel, implements the store-data mux of REQ-006. The FSM and counter stay in mem_stage_ctrl.

Verification
REQ-036 Read, FWD = 00, addr = 0x100; mem_ack on the 3rd ACCESS cycle with rdata = 0xDEADBEEF. Required: stall high 4 cycles; read_data = 0xDEADBEEF; one read_valid pulse in DONE.
REQ-037 Write, FWD = 10, output_data_2 = 0x11, wb_result = 0x22. Required: mem_we = 1, mem_wdata = 0x22, mem_addr = ex_mem_addr; no read_valid.
REQ-038 Read, no ack, TIMEOUT = 4. Required: mem_req drops after 4 ACCESS cycles; timeout_err = 1; read_data = 0; read_valid pulses. The next request clears timeout_err.
REQ-039 Timeout cycle coincides with mem_ack = 1, rdata = 0x5A5A5A5A. Required: timeout_err = 0; read_data = 0x5A5A5A5A.
REQ-040 rst_n pulsed low in the 2nd ACCESS cycle of a write. Required: mem_req, stall and all other outputs go to 0 immediately; IDLE after release; a new read completes normally.
REQ-041 memread = memwrite = 1, FWD = 00, output_data_2 = 0x77. Required: write issued with mem_wdata = 0x77; read_valid stays 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory-stage controller: FSM states, store-forward
// select encodings and the default access timeout.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StDone   = 2'b10
  } state_e;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/store_fwd_sel.sv
// Store-data forwarding mux: picks the value being written back when a
// forwarding hazard is flagged, otherwise the rs2 value from EX/MEM.
module store_fwd_sel
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  fwd_sel,
  input  logic [31:0] rs2_data,
  input  logic [31:0] wb_result,
  output logic [31:0] store_data
);

  always_comb begin
    store_data = rs2_data;
    case (fwd_sel)
      FWD_MEM, FWD_WB: store_data = wb_result;
      default:         store_data = rs2_data;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues one registered memory request per load/store,
// stalls the pipeline until ack or timeout, and returns captured load data.
module mem_stage_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic [1:0]  ex_mem_FWD_RS2,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_output_data_2,
  input  logic [31:0] wb_result,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic        timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              terr_q, terr_d;
  logic              stall_c;
  logic              access_req;
  logic [31:0]       store_data;

  assign access_req = ex_mem_memread | ex_mem_memwrite;

  store_fwd_sel u_store_fwd_sel (
    .fwd_sel    (ex_mem_FWD_RS2),
    .rs2_data   (ex_mem_output_data_2),
    .wb_result  (wb_result),
    .store_data (store_data)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    terr_d   = terr_q;
    stall_c  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access_req) begin
          stall_c = 1'b1;
          state_d = StAccess;
          cnt_d   = '0;
          req_d   = 1'b1;
          // A simultaneous read and write request is issued as a write.
          we_d    = ex_mem_memwrite;
          addr_d  = ex_mem_addr;
          wdata_d = store_data;
          terr_d  = 1'b0;
        end
      end
      StAccess: begin
        stall_c = 1'b1;
        if (!mem_ack && cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // Ack takes priority over a coincident timeout.
        if (mem_ack) begin
          state_d  = StDone;
          req_d    = 1'b0;
          rvalid_d = ~we_q;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (cnt_q == CntLast) begin
          state_d  = StDone;
          req_d    = 1'b0;
          terr_d   = 1'b1;
          rvalid_d = ~we_q;
          if (!we_q) begin
            rdata_d = '0;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      terr_q   <= terr_d;
    end
  end

  // The request decode is combinational, so mask it while reset is held.
  assign stall       = stall_c & rst_n;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign read_data   = rdata_q;
  assign read_valid  = rvalid_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr;
  logic [1:0]  fwd;
  logic [31:0] addr, d2, wb;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] read_data;
  logic        read_valid;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the outstanding transaction.
  bit          m_busy, m_done, m_we, m_terr;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int stall_cnt, rv_cnt, req_cnt;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_mem_memread       (rd),
    .ex_mem_memwrite      (wr),
    .ex_mem_FWD_RS2       (fwd),
    .ex_mem_addr          (addr),
    .ex_mem_output_data_2 (d2),
    .wb_result            (wb),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ack              (mem_ack),
    .mem_rdata            (mem_rdata),
    .stall                (stall),
    .read_data            (read_data),
    .read_valid           (read_valid),
    .timeout_err          (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_we = 0; m_terr = 0; m_waited = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  task automatic compare_all();
    logic exp_stall;
    exp_stall = rst_n && (m_busy || (!m_done && (rd || wr)));
    check("stall",       {31'b0, stall},       {31'b0, exp_stall});
    check("mem_req",     {31'b0, mem_req},     {31'b0, m_busy});
    check("mem_we",      {31'b0, mem_we},      {31'b0, m_we});
    check("mem_addr",    mem_addr,             m_addr);
    check("mem_wdata",   mem_wdata,            m_wdata);
    check("read_data",   read_data,            m_rdata);
    check("read_valid",  {31'b0, read_valid},  {31'b0, (m_done && !m_we)});
    check("timeout_err", {31'b0, timeout_err}, {31'b0, m_terr});
  endtask

  task automatic model_clock();
    if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0; m_done = 1;
        if (!m_we) m_rdata = mem_rdata;
      end else if (m_waited == TO - 1) begin
        m_busy = 0; m_done = 1; m_terr = 1;
        if (!m_we) m_rdata = '0;
      end else begin
        m_waited++;
      end
    end else if (rd || wr) begin
      m_busy   = 1;
      m_waited = 0;
      m_we     = wr;
      m_addr   = addr;
      m_wdata  = (fwd == 2'b01 || fwd == 2'b10) ? wb : d2;
      m_terr   = 0;
    end
  endtask

  task automatic step(input logic i_rd, input logic i_wr, input logic [1:0] i_fwd,
                      input logic [31:0] i_addr, input logic [31:0] i_d2,
                      input logic [31:0] i_wb, input logic i_ack, input logic [31:0] i_rdata);
    @(negedge clk);
    rd = i_rd; wr = i_wr; fwd = i_fwd; addr = i_addr; d2 = i_d2; wb = i_wb;
    mem_ack = i_ack; mem_rdata = i_rdata;
    #1;
    compare_all();
    stall_cnt += int'(stall);
    rv_cnt    += int'(read_valid);
    req_cnt   += int'(mem_req);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic clear_counts();
    stall_cnt = 0; rv_cnt = 0; req_cnt = 0;
  endtask

  // Assert reset part-way through a low clock phase, check, then release.
  task automatic mid_reset(input int dly);
    @(negedge clk);
    #(dly);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req",   {31'b0, mem_req}, 32'h0);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rd = 0; wr = 0; mem_ack = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rd = 0; wr = 0; fwd = 0; addr = 0; d2 = 0; wb = 0;
    mem_ack = 0; mem_rdata = 0;
    model_reset();
    clear_counts();
    #3;
    check("reset_req",   {31'b0, mem_req},     32'h0);
    check("reset_stall", {31'b0, stall},       32'h0);
    check("reset_rdata", read_data,            32'h0);
    check("reset_terr",  {31'b0, timeout_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Read, ack on third access cycle.
    clear_counts();
    step(1, 0, 2'b00, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h100, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h100, 32'h0, 32'h0, 1, 32'hDEADBEEF);
    check("rd_data_lit", read_data, 32'hDEADBEEF);
    check("rd_valid_lit", {31'b0, read_valid}, 32'h1);
    idle_step();
    idle_step();
    check("rd_stall_cycles", stall_cnt, 4);
    check("rd_valid_pulses", rv_cnt, 1);

    // Write with writeback forwarding.
    clear_counts();
    step(0, 1, 2'b10, 32'h2000, 32'h11, 32'h22, 0, 32'h0);
    check("wr_we_lit",    {31'b0, mem_we}, 32'h1);
    check("wr_wdata_lit", mem_wdata, 32'h22);
    check("wr_addr_lit",  mem_addr, 32'h2000);
    step(0, 1, 2'b10, 32'h2000, 32'h11, 32'h22, 1, 32'h0);
    idle_step();
    idle_step();
    check("wr_stall_cycles", stall_cnt, 2);
    check("wr_no_valid", rv_cnt, 0);

    // Read timeout.
    clear_counts();
    step(1, 0, 2'b00, 32'h300, 32'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < int'(TO); i++) step(1, 0, 2'b00, 32'h300, 32'h0, 32'h0, 0, 32'h0);
    check("to_req_cycles", req_cnt, TO);
    check("to_req_low", {31'b0, mem_req}, 32'h0);
    check("to_err_lit", {31'b0, timeout_err}, 32'h1);
    check("to_rdata_lit", read_data, 32'h0);
    check("to_valid_lit", {31'b0, read_valid}, 32'h1);
    idle_step();
    step(0, 1, 2'b00, 32'h304, 32'h9, 32'h0, 0, 32'h0);
    check("to_err_clear", {31'b0, timeout_err}, 32'h0);
    step(0, 1, 2'b00, 32'h304, 32'h9, 32'h0, 1, 32'h0);
    idle_step();

    // Ack coinciding with the timeout cycle.
    step(1, 0, 2'b00, 32'h400, 32'h0, 32'h0, 0, 32'h0);
    for (int i = 0; i < int'(TO) - 1; i++) step(1, 0, 2'b00, 32'h400, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h400, 32'h0, 32'h0, 1, 32'h5A5A5A5A);
    check("race_err_lit", {31'b0, timeout_err}, 32'h0);
    check("race_rdata_lit", read_data, 32'h5A5A5A5A);
    idle_step();

    // Reset during the second access cycle of a write.
    step(0, 1, 2'b00, 32'h500, 32'hABCD, 32'h0, 0, 32'h0);
    step(0, 1, 2'b00, 32'h500, 32'hABCD, 32'h0, 0, 32'h0);
    wr = 1;
    mid_reset(2);
    check("rst_wdata_lit", mem_wdata, 32'h0);
    step(1, 0, 2'b00, 32'h600, 32'h0, 32'h0, 0, 32'h0);
    step(1, 0, 2'b00, 32'h600, 32'h0, 32'h0, 1, 32'h12345678);
    check("post_rst_rdata", read_data, 32'h12345678);
    idle_step();

    // Read and write together: treated as a write.
    clear_counts();
    step(1, 1, 2'b00, 32'h700, 32'h77, 32'h99, 0, 32'h0);
    check("rw_we_lit", {31'b0, mem_we}, 32'h1);
    check("rw_wdata_lit", mem_wdata, 32'h77);
    step(1, 1, 2'b00, 32'h700, 32'h77, 32'h99, 1, 32'hFFFF0000);
    idle_step();
    check("rw_no_valid", rv_cnt, 0);
    check("rw_rdata_held", read_data, 32'h12345678);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rd = 1'($urandom); wr = 1'($urandom);
        mid_reset(int'($urandom_range(1, 3)));
      end else begin
        step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 2'($urandom),
             $urandom, $urandom, $urandom, ($urandom_range(0, 3) == 0), $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
